rx_bit_controller: RTL
======================

Name: rx_bit_controller

Overview:
Receive-side timing and packet sequencer for the USB full-speed RX path. It consumes the per-clock `d_edge` pulse from the RX edge detector, the NRZI-decoded bit `d_orig`, and the synchronized SE0 flag `eop`. It recovers bit timing (8 clocks per bit), strips stuffed bits, checks the SYNC pattern and frames bytes. Its strobes drive the RX shift register and the RX FIFO write logic.

Parameters:
CLKS_PER_BIT, 8, clocks per USB bit; counter width is clog2(CLKS_PER_BIT).
SAMPLE_PT, 3, value of the bit-phase counter at which a bit is sampled; must be less than CLKS_PER_BIT.
STUFF_LIMIT, 6, number of consecutive decoded 1s after which the next bit is a stuff bit.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
d_edge  input  1  one-cycle pulse on any D+ transition (registered edge-detector output)
d_orig  input  1  NRZI-decoded bit value, valid at sample points
eop  input  1  SE0 detected, already synchronized
shift_enable  output  1  one-cycle pulse: shift `d_orig` into the RX shift register
byte_received  output  1  one-cycle pulse: a full data byte has been shifted in
rcving  output  1  high while a packet is in progress
eop_done  output  1  one-cycle pulse on a clean end of packet
rx_error  output  1  sticky error flag

Behaviour:
- Reset is asynchronous, on `n_rst` = 0, with clk as the clock.
- Reset values:
  - state = IDLE.
  - Bit-phase counter `phase` = 0; bit counter = 0; ones counter = 0.
  - All outputs = 0.
- Phase counter, in every state except IDLE:
  - `d_edge` = 1: `phase` <= 0 (resynchronization).
  - Otherwise `phase` <= (`phase` + 1) mod CLKS_PER_BIT.
- A sample point is any cycle with `phase` == SAMPLE_PT and state in SYNC or RECEIVE.
- Outputs are combinational decodes of registered state and counters, plus the current `d_orig`/`eop`. Pulses are exactly one cycle wide.
- Stuff handling, at each sample point:
  - If the ones counter == STUFF_LIMIT, the bit is a stuff bit:
    - No `shift_enable`; ones counter <= 0.
    - If `d_orig` = 1, go to ERR (stuff error).
  - Otherwise:
    - If `d_orig` = 1, ones counter increments (saturating at STUFF_LIMIT); else ones counter <= 0.
- States:
  - IDLE:
    - `rcving` = 0.
    - `d_edge` -> SYNC, with `phase` <= 0, bit counter <= 0, ones counter <= 0 and `rx_error` <= 0.
  - SYNC:
    - `rcving` = 1. Each non-stuff sample is compared with the expected SYNC bit (LSB first 0,0,0,0,0,0,0,1, i.e. byte 0x80). No `shift_enable` is issued in SYNC.
    - Mismatch -> ERR.
    - Eighth bit matches -> RECEIVE, bit counter <= 0.
    - `eop` at a sample point -> ERR.
  - RECEIVE:
    - `rcving` = 1.
    - Each non-stuff sample asserts `shift_enable` and increments the bit counter mod 8.
    - `byte_received` pulses in the cycle after the 8th `shift_enable` of a byte.
    - `eop` = 1 at a sample point has priority over data; no shift occurs. Then:
      - bit counter == 0 -> EOP_WAIT, with `eop_done` pulsing on entry.
      - bit counter != 0 -> ERR (partial byte).
  - EOP_WAIT:
    - `rcving` = 1.
    - `eop` = 0 -> IDLE (J state restored).
  - ERR:
    - `rx_error` = 1; `rcving` = 0.
    - Stays in ERR until `eop` has been seen at 1 and then at 0, then -> IDLE.
    - `rx_error` stays high through IDLE until the next packet start.
- Simultaneous `d_edge` and sample point: the sample is taken on the current `phase`, and the counter reset applies for the next cycle.
- Reset mid-packet aborts immediately; no pulse is emitted.

Test Plan:
1. Reset, then an ideal SYNC (00000001), then byte 0xA5 (LSB first), then EOP with 2-bit SE0 -> exactly 8 `shift_enable` pulses, each at `phase` 3 (8 clocks apart), then one `byte_received`, then `eop_done` once. `rcving` falls 1 cycle after `eop` drops; `rx_error` = 0.
2. Data 0x7F then 0xFF (runs of 1s) -> a stuff bit is expected after every 6 ones, and `shift_enable` count is still 16. A stuffed 1 instead of 0 -> ERR, `rx_error` = 1, no further `shift_enable`.
3. SYNC with bit 4 = 1 -> ERR on that sample; `rcving` = 0; no `shift_enable` ever asserted.
4. EOP after 5 data bits -> no `eop_done`, `rx_error` = 1. After SE0 ends -> IDLE; the next `d_edge` clears `rx_error`.
5. Jitter: edges arriving at +1 and -1 clock relative to nominal -> sampling stays at 3 clocks after each edge; received byte correct.
6. `n_rst` asserted during RECEIVE bit 3 -> all outputs 0 asynchronously; the next clean packet is received correctly.

Source files
------------

// File: rtl/rx_bit_controller.sv
// USB full-speed receive sequencer: bit-timing recovery, stuff-bit removal,
// SYNC checking and byte framing for the RX shift register and FIFO.
module rx_bit_controller #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = 3,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_edge,
    input  logic d_orig,
    input  logic eop,
    output logic shift_enable,
    output logic byte_received,
    output logic rcving,
    output logic eop_done,
    output logic rx_error
);

    // state    | meaning
    // IDLE     | bus idle (J), waiting for the first transition
    // SYNC     | checking the 00000001 SYNC field
    // RECEIVE  | shifting data bits, framing bytes
    // EOP_WAIT | clean EOP seen, waiting for SE0 to end
    // ERR      | error, waiting for SE0 to come and go
    typedef enum logic [2:0] {IDLE, SYNC, RECEIVE, EOP_WAIT, ERR} state_t;

    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam logic [PW-1:0] SAMPLE_V = PW'(SAMPLE_PT);
    localparam logic [PW-1:0] LAST_V   = PW'(CLKS_PER_BIT - 1);
    localparam logic [OW-1:0] STUFF_V  = OW'(STUFF_LIMIT);

    state_t        state;
    logic [PW-1:0] phase;
    logic [PW-1:0] next_phase;
    logic [2:0]    bit_cnt;
    logic [OW-1:0] ones;
    logic          byte_flag;
    logic          eop_flag;
    logic          err_flag;
    logic          eop_seen;
    logic          sample;
    logic          stuff_bit;
    logic          sync_bit;

    assign next_phase = (phase == LAST_V) ? '0 : phase + 1'b1;
    assign sample     = (phase == SAMPLE_V) && ((state == SYNC) || (state == RECEIVE));
    assign stuff_bit  = (ones == STUFF_V);
    assign sync_bit   = (bit_cnt == 3'd7);

    assign shift_enable  = sample && (state == RECEIVE) && !eop && !stuff_bit;
    assign byte_received = byte_flag;
    assign eop_done      = eop_flag;
    assign rx_error      = err_flag;
    assign rcving        = (state == SYNC) || (state == RECEIVE) || (state == EOP_WAIT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            phase     <= '0;
            bit_cnt   <= '0;
            ones      <= '0;
            byte_flag <= 1'b0;
            eop_flag  <= 1'b0;
            err_flag  <= 1'b0;
            eop_seen  <= 1'b0;
        end else begin
            byte_flag <= 1'b0;
            eop_flag  <= 1'b0;
            // an edge realigns the bit clock; a coincident sample still uses the old phase
            if (state != IDLE)
                phase <= d_edge ? '0 : next_phase;

            case (state)
                IDLE: begin
                    if (d_edge) begin
                        state    <= SYNC;
                        phase    <= '0;
                        bit_cnt  <= '0;
                        ones     <= '0;
                        err_flag <= 1'b0;
                    end
                end

                SYNC: begin
                    if (sample) begin
                        if (eop) begin
                            state    <= ERR;
                            err_flag <= 1'b1;
                            eop_seen <= 1'b1;
                        end else if (stuff_bit) begin
                            ones <= '0;
                            if (d_orig) begin
                                state    <= ERR;
                                err_flag <= 1'b1;
                                eop_seen <= 1'b0;
                            end
                        end else begin
                            ones <= d_orig ? ones + 1'b1 : '0;
                            if (d_orig != sync_bit) begin
                                state    <= ERR;
                                err_flag <= 1'b1;
                                eop_seen <= 1'b0;
                            end else if (sync_bit) begin
                                state   <= RECEIVE;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                end

                RECEIVE: begin
                    if (sample) begin
                        if (eop) begin
                            if (bit_cnt == 3'd0) begin
                                state    <= EOP_WAIT;
                                eop_flag <= 1'b1;
                            end else begin
                                state    <= ERR;
                                err_flag <= 1'b1;
                                eop_seen <= 1'b1;
                            end
                        end else if (stuff_bit) begin
                            ones <= '0;
                            if (d_orig) begin
                                state    <= ERR;
                                err_flag <= 1'b1;
                                eop_seen <= 1'b0;
                            end
                        end else begin
                            ones    <= d_orig ? ones + 1'b1 : '0;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                byte_flag <= 1'b1;
                        end
                    end
                end

                EOP_WAIT: begin
                    if (!eop)
                        state <= IDLE;
                end

                ERR: begin
                    if (eop)
                        eop_seen <= 1'b1;
                    else if (eop_seen)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
